// File: rtl/window_discriminator_multi.sv
// Purpose : multi-channel window/threshold discriminator; AND-qualifies NUM_CH DAC
//           channels each sample, counts consecutive qualifying samples, then
//           fires a programmable stim pulse followed by a refractory lockout.
// Latency : all outputs registered; stim_out rises on the edge that sees the
//           (stop_max+1)-th consecutive qualifying sample (stop_max 0 acts as 1).
// Backpressure: none; one evaluation per sample_CLK_out edge, no stalls.
//
// Ports:
//   sample_CLK_out, reset (sync, active-high), fsm_mode (0 forces idle)
//   ch_en / ch_in_window / ch_thresh / ch_edge_type : per-channel flags
//   stop_max, stim_len, refract_len : run-time timing controls
//   fsm_state, fsm_out, fsm_counter, stim_out, stim_events : status to host
module window_discriminator_multi #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 16
) (
    input  logic              sample_CLK_out,
    input  logic              reset,
    input  logic              fsm_mode,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] ch_in_window,
    input  logic [NUM_CH-1:0] ch_thresh,
    input  logic [NUM_CH-1:0] ch_edge_type,
    input  logic [CNT_W-1:0]  stop_max,
    input  logic [CNT_W-1:0]  stim_len,
    input  logic [CNT_W-1:0]  refract_len,
    output logic [1:0]        fsm_state,
    output logic [7:0]        fsm_out,
    output logic [CNT_W-1:0]  fsm_counter,
    output logic              stim_out,
    output logic [15:0]       stim_events
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRACK   = 2'd1,
        S_STIM    = 2'd2,
        S_REFRACT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  phase_q;
    logic [CNT_W-1:0]  phase_d;
    logic [15:0]       events_d;
    logic [7:0]        fsm_out_d;
    logic              stim_d;

    logic              any_en;
    logic [NUM_CH-1:0] ch_ok;
    logic              advance;
    logic [CNT_W-1:0]  stim_eff;

    // A disabled or out-of-window channel never blocks; an active channel must
    // show a threshold flag that differs from its polarity bit.
    assign any_en   = |ch_en;
    assign ch_ok    = ~ch_en | ~ch_in_window | (ch_thresh ^ ch_edge_type);
    assign advance  = any_en & (&ch_ok);
    assign stim_eff = (stim_len == '0) ? ONE : stim_len;

    always_comb begin
        state_d  = state_q;
        cnt_d    = fsm_counter;
        phase_d  = phase_q;
        events_d = stim_events;

        if (!fsm_mode) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            phase_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (advance) begin
                        state_d = S_TRACK;
                        cnt_d   = ONE;
                    end
                end
                S_TRACK: begin
                    if (!advance) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (fsm_counter >= stop_max) begin
                        state_d  = S_STIM;
                        cnt_d    = '0;
                        phase_d  = ONE;
                        events_d = (stim_events == 16'hFFFF) ? stim_events
                                                             : stim_events + 16'd1;
                    end else begin
                        // Bounded by stop_max, so this cannot wrap.
                        cnt_d = fsm_counter + ONE;
                    end
                end
                S_STIM: begin
                    if (phase_q >= stim_eff) begin
                        if (refract_len != '0) begin
                            state_d = S_REFRACT;
                            phase_d = ONE;
                        end else begin
                            state_d = S_IDLE;
                            phase_d = '0;
                        end
                    end else begin
                        phase_d = phase_q + ONE;
                    end
                end
                S_REFRACT: begin
                    if (phase_q >= refract_len) begin
                        state_d = S_IDLE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    phase_d = '0;
                end
            endcase
        end

        // Status outputs are registered alongside the state they describe.
        fsm_out_d = 8'h00;
        stim_d    = 1'b0;
        if (fsm_mode) begin
            case (state_d)
                S_IDLE:    fsm_out_d = 8'b0100_0000;
                S_TRACK:   fsm_out_d = 8'b0010_0000;
                S_STIM:    fsm_out_d = 8'b0001_0000;
                S_REFRACT: fsm_out_d = 8'b0000_1000;
                default:   fsm_out_d = 8'b0100_0000;
            endcase
            stim_d = (state_d == S_STIM);
        end
    end

    always_ff @(posedge sample_CLK_out) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fsm_counter <= '0;
            phase_q     <= '0;
            fsm_out     <= 8'b0100_0000;
            stim_out    <= 1'b0;
            stim_events <= 16'd0;
        end else begin
            state_q     <= state_d;
            fsm_counter <= cnt_d;
            phase_q     <= phase_d;
            fsm_out     <= fsm_out_d;
            stim_out    <= stim_d;
            stim_events <= events_d;
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_window_discriminator_multi.sv
module tb_window_discriminator_multi;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 16;

    logic              sample_CLK_out;
    logic              reset;
    logic              fsm_mode;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ch_in_window;
    logic [NUM_CH-1:0] ch_thresh;
    logic [NUM_CH-1:0] ch_edge_type;
    logic [CNT_W-1:0]  stop_max;
    logic [CNT_W-1:0]  stim_len;
    logic [CNT_W-1:0]  refract_len;
    logic [1:0]        fsm_state;
    logic [7:0]        fsm_out;
    logic [CNT_W-1:0]  fsm_counter;
    logic              stim_out;
    logic [15:0]       stim_events;

    int total = 0;
    int bad   = 0;

    window_discriminator_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .sample_CLK_out (sample_CLK_out),
        .reset          (reset),
        .fsm_mode       (fsm_mode),
        .ch_en          (ch_en),
        .ch_in_window   (ch_in_window),
        .ch_thresh      (ch_thresh),
        .ch_edge_type   (ch_edge_type),
        .stop_max       (stop_max),
        .stim_len       (stim_len),
        .refract_len    (refract_len),
        .fsm_state      (fsm_state),
        .fsm_out        (fsm_out),
        .fsm_counter    (fsm_counter),
        .stim_out       (stim_out),
        .stim_events    (stim_events)
    );

    initial sample_CLK_out = 1'b0;
    always #5 sample_CLK_out = ~sample_CLK_out;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Advance one sample edge, then sample outputs just after it.
    task automatic tick();
        @(posedge sample_CLK_out);
        #1;
    endtask

    task automatic expect_all(input string tag, input int st, input int out,
                              input int cnt, input int stim, input int ev);
        check_val({tag, ".state"}, 32'(fsm_state),   32'(st));
        check_val({tag, ".out"},   32'(fsm_out),     32'(out));
        check_val({tag, ".cnt"},   32'(fsm_counter), 32'(cnt));
        check_val({tag, ".stim"},  32'(stim_out),    32'(stim));
        check_val({tag, ".ev"},    32'(stim_events), 32'(ev));
    endtask

    // Hand-computed trace for stop_max=3, stim_len=2, refract_len=4.
    int basic_st  [10] = '{1, 1, 1, 2, 2, 3, 3, 3, 3, 0};
    int basic_out [10] = '{'h20, 'h20, 'h20, 'h10, 'h10, 'h08, 'h08, 'h08, 'h08, 'h40};
    int basic_cnt [10] = '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0};
    int basic_stim[10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    int basic_ev  [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};

    initial begin
        reset        = 1'b1;
        fsm_mode     = 1'b1;
        ch_en        = 8'h01;
        ch_in_window = 8'h01;
        ch_thresh    = 8'h01;
        ch_edge_type = 8'h00;
        stop_max     = 16'd3;
        stim_len     = 16'd2;
        refract_len  = 16'd4;

        // Reset held two cycles with advance high.
        tick();
        tick();
        expect_all("reset", 0, 'h40, 0, 0, 0);

        // Basic stim cycle.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) ch_thresh = 8'h00;  // ignored while in REFRACT
            tick();
            expect_all($sformatf("basic%0d", i), basic_st[i], basic_out[i],
                       basic_cnt[i], basic_stim[i], basic_ev[i]);
        end
        tick();
        expect_all("basic_idle", 0, 'h40, 0, 0, 1);

        // Qualification drops on the 3rd sample.
        ch_thresh = 8'h01;
        tick();
        expect_all("brk1", 1, 'h20, 1, 0, 1);
        tick();
        expect_all("brk2", 1, 'h20, 2, 0, 1);
        ch_thresh = 8'h00;
        tick();
        expect_all("brk3", 0, 'h40, 0, 0, 1);

        // Multi-channel AND: ch2 in window and failing blocks ch0.
        ch_en        = 8'h05;
        ch_in_window = 8'h05;
        ch_thresh    = 8'h01;
        tick();
        expect_all("and_block", 0, 'h40, 0, 0, 1);
        ch_in_window = 8'h01;
        tick();
        expect_all("and_pass", 1, 'h20, 1, 0, 1);
        ch_thresh = 8'h00;
        tick();
        expect_all("and_drop", 0, 'h40, 0, 0, 1);

        // All channels disabled never leaves IDLE.
        ch_en        = 8'h00;
        ch_in_window = 8'hFF;
        ch_thresh    = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_all($sformatf("dis%0d", i), 0, 'h40, 0, 0, 1);
        end

        // stop_max=0, stim_len=0, refract_len=0: 1-cycle stim straight to IDLE.
        ch_en        = 8'h01;
        ch_in_window = 8'h01;
        ch_thresh    = 8'h01;
        stop_max     = 16'd0;
        stim_len     = 16'd0;
        refract_len  = 16'd0;
        tick();
        expect_all("zero_trk", 1, 'h20, 1, 0, 1);
        tick();
        expect_all("zero_stim", 2, 'h10, 0, 1, 2);
        tick();
        expect_all("zero_idle", 0, 'h40, 0, 0, 2);
        ch_thresh = 8'h00;
        tick();
        expect_all("zero_hold", 0, 'h40, 0, 0, 2);

        // Mode drop mid-stim aborts but keeps the event count.
        stop_max  = 16'd1;
        stim_len  = 16'd5;
        ch_thresh = 8'h01;
        tick();
        expect_all("ab_trk", 1, 'h20, 1, 0, 2);
        tick();
        expect_all("ab_stim1", 2, 'h10, 0, 1, 3);
        tick();
        expect_all("ab_stim2", 2, 'h10, 0, 1, 3);
        fsm_mode = 1'b0;
        tick();
        expect_all("ab_off", 0, 'h00, 0, 0, 3);
        ch_thresh = 8'h00;
        fsm_mode  = 1'b1;
        tick();
        expect_all("ab_on", 0, 'h40, 0, 0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
